// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  // Sequencer states, in the order the normal bring-up walks through them.
  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_sup_state_t;

  // Bits needed to hold max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 2) begin
      return 1;
    end
    return unsigned'($clog2(max_val + 1));
  endfunction

  // Largest of three reload values, used to size the shared counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_sup_sync2.sv
// Two-flop synchronizer bringing the asynchronous PLL locked flag into
// the refclk domain. Both stages clear to 0 so a reset never reports lock.
module pll_sup_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops to resolve metastability.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset / lock-acquisition sequencer running on the free-running refclk.
// Holds the PLL in reset, waits for lock with a timeout, debounces lock,
// then releases the downstream reset. Failures retry a bounded number of
// times before latching a fault.
// Optional macro PLL_SUP_RETRY_CNT_EN exposes the retry counter as a port.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic refclk,
  input  logic rst,
  input  logic pll_locked,
  input  logic relock_req,
  output logic pll_rst,
  output logic user_rst,
  output logic ready,
  output logic fault
`ifdef PLL_SUP_RETRY_CNT_EN
  ,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
`endif
);

  // One down-counter is shared by every timed state; size it for the longest.
  localparam int unsigned CNT_MAX = max3(RST_CYCLES - 1, LOCK_TIMEOUT - 1, STABLE_CYCLES - 1);
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam int unsigned RC_W    = cnt_width(MAX_RETRY);

  // Reload values: a state is left on the cycle its counter is seen at zero.
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LOAD  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRY);

  pll_sup_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RC_W-1:0]  retry_q, retry_d;
  logic             pll_rst_q, pll_rst_d;
  logic             user_rst_q, user_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             fail;
  logic             lk_s;

  pll_sup_sync2 u_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lk_s)
  );

  // Next-state, counter reload and output decode; relock overrides the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail    = 1'b0;

    if (relock_req) begin
      state_d = ST_RESET_PLL;
      cnt_d   = RST_LOAD;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == '0) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = TO_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock seen on the final timeout cycle still counts as lock.
          if (lk_s) begin
            state_d = ST_STABLE;
            cnt_d   = ST_LOAD;
          end else if (cnt_q == '0) begin
            fail = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_STABLE: begin
          // A dropout restarts the whole wait, including a fresh timeout.
          if (!lk_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = TO_LOAD;
          end else if (cnt_q == '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (!lk_s) begin
            fail = 1'b1;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = RST_LOAD;
        end
      endcase

      if (fail) begin
        if (retry_q == RC_MAX) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = ST_RESET_PLL;
          cnt_d   = RST_LOAD;
        end
      end
    end

    // Outputs follow the state being entered so they register with it.
    pll_rst_d  = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    user_rst_d = (state_d != ST_RUN);
    ready_d    = (state_d == ST_RUN);
    fault_d    = (state_d == ST_FAULT);
  end

  // State, counter, retry count and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= ST_RESET_PLL;
      cnt_q      <= RST_LOAD;
      retry_q    <= '0;
      pll_rst_q  <= 1'b1;
      user_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pll_rst_q  <= pll_rst_d;
      user_rst_q <= user_rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  assign pll_rst  = pll_rst_q;
  assign user_rst = user_rst_q;
  assign ready    = ready_q;
  assign fault    = fault_q;
`ifdef PLL_SUP_RETRY_CNT_EN
  assign retry_cnt = retry_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: a vector table, hand-timed
// corner sequences, then random lock/relock/reset traffic against a
// behavioural model. Honours PLL_SUP_RETRY_CNT_EN for the optional port.
module tb_pll_lock_supervisor;

  localparam int unsigned RST_C = 4;
  localparam int unsigned TO_C  = 20;
  localparam int unsigned ST_C  = 8;
  localparam int unsigned MR_C  = 2;

  logic refclk;
  logic rst;
  logic pll_locked;
  logic relock_req;
  logic pll_rst;
  logic user_rst;
  logic ready;
  logic fault;
`ifdef PLL_SUP_RETRY_CNT_EN
  logic [1:0] retry_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (ST_C),
    .MAX_RETRY     (MR_C)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .user_rst   (user_rst),
    .ready      (ready),
    .fault      (fault)
`ifdef PLL_SUP_RETRY_CNT_EN
    ,
    .retry_cnt  (retry_cnt)
`endif
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // ---------------- behavioural reference model ----------------
  // Phases with an elapsed-cycle count since phase entry; lock is seen
  // through a two-deep delay queue.
  localparam int P_RSTP = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FLT = 4;
  int   m_phase;
  int   m_elapsed;
  int   m_retry;
  logic m_hist[$];
  logic m_lk;
  logic m_fail;
  logic exp_pr, exp_ur, exp_rd, exp_ft;

  always @(posedge refclk) begin
    if (rst) begin
      m_phase   = P_RSTP;
      m_elapsed = 0;
      m_retry   = 0;
      m_hist    = {1'b0, 1'b0};
    end else begin
      m_lk = m_hist.pop_front();
      m_hist.push_back(pll_locked);
      m_fail = 1'b0;
      if (relock_req) begin
        m_phase   = P_RSTP;
        m_elapsed = 0;
        m_retry   = 0;
      end else begin
        m_elapsed++;
        case (m_phase)
          P_RSTP: if (m_elapsed >= int'(RST_C)) begin m_phase = P_WAIT; m_elapsed = 0; end
          P_WAIT: begin
            if (m_lk) begin m_phase = P_STAB; m_elapsed = 0; end
            else if (m_elapsed >= int'(TO_C)) m_fail = 1'b1;
          end
          P_STAB: begin
            if (!m_lk) begin m_phase = P_WAIT; m_elapsed = 0; end
            else if (m_elapsed >= int'(ST_C)) begin m_phase = P_RUN; m_elapsed = 0; m_retry = 0; end
          end
          P_RUN: if (!m_lk) m_fail = 1'b1;
          default: ;
        endcase
        if (m_fail) begin
          m_elapsed = 0;
          if (m_retry == int'(MR_C)) m_phase = P_FLT;
          else begin m_retry++; m_phase = P_RSTP; end
        end
      end
    end
    exp_pr = (m_phase == P_RSTP) || (m_phase == P_FLT);
    exp_ur = (m_phase != P_RUN);
    exp_rd = (m_phase == P_RUN);
    exp_ft = (m_phase == P_FLT);
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_pr, input logic e_ur,
                         input logic e_rd, input logic e_ft);
    chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(e_pr));
    chk({tag, ".user_rst"}, 32'(user_rst), 32'(e_ur));
    chk({tag, ".ready"}, 32'(ready), 32'(e_rd));
    chk({tag, ".fault"}, 32'(fault), 32'(e_ft));
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return pll_rst;
      1: return user_rst;
      2: return ready;
      default: return fault;
    endcase
  endfunction

  // Tick until the chosen output reaches val; n reports cycles taken (bounded).
  task automatic wait_for(input int which, input logic val, input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sel(which) !== val && n < maxc);
  endtask

  typedef struct {
    logic rst;
    logic relock;
    logic locked;
    int   cyc;
    logic e_pr;
    logic e_ur;
    logic e_rd;
    logic e_ft;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int   n;
    int   len;
    logic lvl, do_rst, do_rl;

    rst = 1'b1;
    relock_req = 1'b0;
    pll_locked = 1'b0;

    // ---------------- vector table ----------------
    vecs[0] = '{1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0}; // reset values
    vecs[1] = '{1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0, 1'b0}; // pll_rst drops after 4
    vecs[2] = '{1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0}; // one short of ready
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0}; // ready on 11th
    vecs[4] = '{1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1, 1'b0}; // loss not yet visible
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0}; // loss on 3rd edge
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0}; // relock
    vecs[7] = '{1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0}; // 4th cycle ends reset

    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst;
      relock_req = vecs[i].relock;
      pll_locked = vecs[i].locked;
      repeat (vecs[i].cyc) tick();
      relock_req = 1'b0;
      chk_out($sformatf("vec%0d", i), vecs[i].e_pr, vecs[i].e_ur, vecs[i].e_rd, vecs[i].e_ft);
      $display("vec %0d: rst=%0b relock=%0b locked=%0b cyc=%0d -> pll_rst=%0b user_rst=%0b ready=%0b fault=%0b",
               i, vecs[i].rst, vecs[i].relock, vecs[i].locked, vecs[i].cyc, pll_rst, user_rst, ready, fault);
    end

    // ---------------- reset release and first lock ----------------
    rst = 1'b1;
    tick();
    tick();
    chk_out("rst_vals", 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    wait_for(0, 1'b0, 50, n);
    chk("rst_hold", 32'(n), 32'd4);
    repeat (10) tick();
    pll_locked = 1'b1;
    wait_for(2, 1'b1, 50, n);
    chk("lock_to_ready", 32'(n), 32'd11);
    chk("run_user_rst", 32'(user_rst), 32'd0);
    $display("seq lock: ready after %0d cycles", n);

    // ---------------- lock loss in RUN ----------------
    pll_locked = 1'b0;
    wait_for(2, 1'b0, 50, n);
    chk("loss_latency", 32'(n), 32'd3);
    chk("loss_user_rst", 32'(user_rst), 32'd1);
    chk("loss_pll_rst", 32'(pll_rst), 32'd1);
`ifdef PLL_SUP_RETRY_CNT_EN
    chk("loss_retry", 32'(retry_cnt), 32'd1);
`endif
    pll_locked = 1'b1;
    wait_for(2, 1'b1, 100, n);
    chk("relock_after_loss", 32'(n), 32'd13);
`ifdef PLL_SUP_RETRY_CNT_EN
    chk("relock_retry_clr", 32'(retry_cnt), 32'd0);
`endif
    $display("seq loss: re-ready after %0d cycles", n);

    // ---------------- dropout during STABLE ----------------
    pll_locked = 1'b0;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("relock_pll_rst", 32'(pll_rst), 32'd1);
    chk("relock_ready", 32'(ready), 32'd0);
    wait_for(0, 1'b0, 50, n);
    chk("relock_hold", 32'(n), 32'd4);
    pll_locked = 1'b1;
    repeat (8) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    pll_locked = 1'b1;
    chk("stable_drop_no_ready", 32'(ready), 32'd0);
    wait_for(2, 1'b1, 50, n);
    chk("stable_drop_ready", 32'(n), 32'd11);
    $display("seq stable drop: ready after %0d cycles", n);

    // ---------------- timeouts into FAULT ----------------
    pll_locked = 1'b0;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_for(0, 1'b0, 50, n);
      chk($sformatf("to%0d_rst_hold", k), 32'(n), 32'd4);
      wait_for(0, 1'b1, 50, n);
      chk($sformatf("to%0d_timeout", k), 32'(n), 32'd20);
      chk($sformatf("to%0d_fault", k), 32'(fault), (k == 2) ? 32'd1 : 32'd0);
`ifdef PLL_SUP_RETRY_CNT_EN
      if (k < 2) chk($sformatf("to%0d_retry", k), 32'(retry_cnt), 32'(k + 1));
`endif
      $display("seq timeout %0d: fault=%0b", k, fault);
    end
    repeat (30) tick();
    chk_out("fault_hold", 1'b1, 1'b1, 1'b0, 1'b1);

    // ---------------- relock out of FAULT ----------------
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("fault_clr", 32'(fault), 32'd0);
    chk("fault_relock_pll_rst", 32'(pll_rst), 32'd1);
`ifdef PLL_SUP_RETRY_CNT_EN
    chk("fault_relock_retry", 32'(retry_cnt), 32'd0);
`endif
    wait_for(0, 1'b0, 50, n);
    chk("fault_relock_hold", 32'(n), 32'd4);
    pll_locked = 1'b1;
    wait_for(2, 1'b1, 50, n);
    chk("fault_relock_ready", 32'(n), 32'd11);
    $display("seq fault relock: ready after %0d cycles", n);

    // ---------------- rst and relock together in RUN ----------------
    rst = 1'b1;
    relock_req = 1'b1;
    tick();
    chk_out("rst_wins", 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    relock_req = 1'b0;
    wait_for(0, 1'b0, 50, n);
    chk("rst_wins_hold", 32'(n), 32'd4);
    $display("seq rst+relock: pll_rst held %0d cycles", n);

    // ---------------- randomized traffic vs model ----------------
    for (int seg = 0; seg < 80; seg++) begin
      do_rst = ($urandom % 25) == 0;
      do_rl  = ($urandom % 12) == 0;
      lvl    = ($urandom % 10) < 7;
      len    = $urandom_range(1, 40);
      rst = do_rst;
      relock_req = do_rl;
      pll_locked = lvl;
      for (int c = 0; c < len; c++) begin
        tick();
        rst = 1'b0;
        relock_req = 1'b0;
        chk_out($sformatf("rnd%0d_%0d", seg, c), exp_pr, exp_ur, exp_rd, exp_ft);
`ifdef PLL_SUP_RETRY_CNT_EN
        chk($sformatf("rnd%0d_%0d.retry", seg, c), 32'(retry_cnt), 32'(m_retry));
`endif
      end
      $display("seg %0d: locked=%0b len=%0d rst=%0b relock=%0b -> ready=%0b fault=%0b",
               seg, lvl, len, do_rst, do_rl, ready, fault);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the reset and lock-acquisition of the board PLL (100 MHz refclk → 125 MHz outclk_0) and produces a clean reset for logic in the PLL output domain. Runs entirely on the free-running refclk, synchronizes the PLL `locked` flag, and requires a debounce interval before declaring the clock good. On timeout or loss of lock it automatically resets the PLL and retries, up to a bounded count, then latches a fault.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (≥1)
- `LOCK_TIMEOUT`, 100000: cycles allowed in WAIT_LOCK before a retry (≥2)
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before RUN (≥1)
- `MAX_RETRY`, 7: failures tolerated before FAULT (≥1)
- `refclk` in 1: sole clock, free-running 100 MHz
- `rst` in 1: synchronous, active-high reset
- `pll_locked` in 1: PLL `locked`, asynchronous to `refclk`
- `relock_req` in 1: single-cycle request to restart the sequence and clear retries
- `pll_rst` out 1: drives PLL `rst`
- `user_rst` out 1: active-high reset for outclk-domain logic (consumer re-synchronizes)
- `ready` out 1: clock qualified, RUN state
- `fault` out 1: sticky, retries exhausted
- `retry_cnt` out $clog2(MAX_RETRY+1): failures since last RUN entry (only with macro, see Configuration)

## Operation
- `pll_locked` passes through 2-flop synchronizer → `lk_s`; all decisions use `lk_s`.
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT. One shared down-counter, reloaded on every state entry.
- RESET_PLL: `pll_rst`=1 for exactly RST_CYCLES cycles → WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0. `lk_s`=1 → STABLE. LOCK_TIMEOUT cycles elapsed without `lk_s` → failure.
- STABLE: `lk_s`=1 for STABLE_CYCLES consecutive cycles → RUN. Any `lk_s`=0 → WAIT_LOCK with fresh timeout.
- RUN: `ready`=1, `user_rst`=0, retry count cleared on entry. `lk_s`=0 for one cycle → failure.
- Failure: if retry count == MAX_RETRY → FAULT, else retry count +1 and → RESET_PLL.
- FAULT: `pll_rst`=1, `fault`=1, `user_rst`=1; left only via `rst` or `relock_req`.
- `relock_req` from any state: → RESET_PLL, retry count cleared, `fault` cleared. Priority: `rst` > `relock_req` > state transitions.
- `user_rst`=1 and `ready`=0 in every state except RUN.

## Timing
- All outputs registered. Reset values: `pll_rst`=1, `user_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0; state RESET_PLL.
- After `rst` deasserts: `pll_rst` high RST_CYCLES cycles, then low.
- `pll_locked` rise → `lk_s` rise 2 cycles later; `ready` rises STABLE_CYCLES+1 cycles after `lk_s` rise; `user_rst` falls on the same edge.
- `pll_locked` fall in RUN → `ready`=0, `user_rst`=1 3 cycles later (2 sync + 1 register); `pll_rst`=1 on that same edge.
- `relock_req` sampled high → `pll_rst`=1, `ready`=0 on next edge.
- Lock glitch shorter than 1 refclk period may be missed; specified, not an error.
- `rst` asserted mid-sequence: full return to reset values next edge, counter and retry count cleared.

## Configuration
- `PLL_SUP_RETRY_CNT_EN` defined: `retry_cnt` port present, reports current retry count.
- Not defined: port absent; retry counting and FAULT behaviour unchanged internally.

## Structure
- Package `pll_sup_pkg`: state enum `pll_sup_state_t`, counter-width helper function.
- Sub-module `pll_sup_sync2`: 2-flop synchronizer for `pll_locked`, reset to 0.
- Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.

## Test plan
- Release `rst`, raise `pll_locked` 10 cycles after `pll_rst` falls, hold → `pll_rst` high 4 cycles; `ready`=1, `user_rst`=0 exactly 2+8+1 cycles after `pll_locked` rise.
- Locked held 0 → three timeouts of 20 cycles, retry_cnt 1, 2, then `fault`=1 with `pll_rst`=1 held indefinitely.
- In STABLE, drop `pll_locked` for 2 cycles at cycle 5 → back to WAIT_LOCK, `ready` only after a fresh 8-cycle stable run.
- In RUN, drop `pll_locked` → `ready`=0, `user_rst`=1, `pll_rst`=1 3 cycles later; retry_cnt=1; relock succeeds, retry_cnt returns 0.
- In FAULT, pulse `relock_req` → `fault`=0, retry_cnt=0, `pll_rst` held 4 cycles, normal lock sequence follows.
- Assert `rst` same cycle as `relock_req` during RUN → reset values next edge; `rst` wins.
